// File: rtl/dcache_s2_pipe_if.sv
// Request bundle from the dcache s1 stage and the registered s2 view handed back to it.
interface dcache_s2_pipe_if #(
   parameter int NWAYS  = 4,
   parameter int TAG_W  = 20,
   parameter int IDX_W  = 6,
   parameter int NBYP   = 3,
   parameter int DATA_W = 64,
   parameter int ROW_W  = 128
);
   localparam int PADDR_W = TAG_W + IDX_W + 6;

   logic                      s1_valid;
   logic                      s1_kill;
   logic                      s1_replay;
   logic                      s1_clk_en;
   logic [PADDR_W-1:0]        s1_paddr;
   logic [4:0]                s1_cmd;
   logic [DATA_W-1:0]         s1_wdata;
   logic                      s1_nack;
   logic [NWAYS*TAG_W-1:0]    meta_tag_in;
   logic [NWAYS*2-1:0]        meta_state_in;
   logic [NWAYS*ROW_W-1:0]    data_in;
   logic [NBYP-1:0]           byp_valid;
   logic [NBYP-1:0]           byp_write;
   logic [NBYP*PADDR_W-1:0]   byp_addr;
   logic [NBYP*DATA_W-1:0]    byp_data;
   logic                      flush;

   logic                      s1_ready;
   logic                      s2_valid;
   logic                      s2_killed;
   logic                      s2_replay;
   logic                      s2_nack;
   logic                      s2_hit;
   logic [PADDR_W-1:0]        s2_addr;
   logic [4:0]                s2_cmd;
   logic [DATA_W-1:0]         s2_wdata;
   logic [NWAYS-1:0]          s2_hit_way;
   logic [NWAYS-1:0]          s2_victim_way;
   logic [NWAYS*TAG_W-1:0]    s2_meta_tag;
   logic [NWAYS*2-1:0]        s2_meta_state;
   logic [NWAYS*ROW_W-1:0]    s2_rows;
   logic                      s2_store_bypass;
   logic [DATA_W-1:0]         s2_bypass_data;

   modport master (
      output s1_valid, s1_kill, s1_replay, s1_clk_en, s1_paddr, s1_cmd, s1_wdata, s1_nack,
             meta_tag_in, meta_state_in, data_in, byp_valid, byp_write, byp_addr, byp_data, flush,
      input  s1_ready, s2_valid, s2_killed, s2_replay, s2_nack, s2_hit, s2_addr, s2_cmd,
             s2_wdata, s2_hit_way, s2_victim_way, s2_meta_tag, s2_meta_state, s2_rows,
             s2_store_bypass, s2_bypass_data
   );

   modport slave (
      input  s1_valid, s1_kill, s1_replay, s1_clk_en, s1_paddr, s1_cmd, s1_wdata, s1_nack,
             meta_tag_in, meta_state_in, data_in, byp_valid, byp_write, byp_addr, byp_data, flush,
      output s1_ready, s2_valid, s2_killed, s2_replay, s2_nack, s2_hit, s2_addr, s2_cmd,
             s2_wdata, s2_hit_way, s2_victim_way, s2_meta_tag, s2_meta_state, s2_rows,
             s2_store_bypass, s2_bypass_data
   );
endinterface

// File: rtl/dcache_s2_pipe.sv
// Dcache s1->s2 pipeline register: tag compare, PLRU/invalid victim select, store bypass, PLRU flush.
// Latency: one cycle from s1 inputs to s2 outputs.
// Backpressure: s1_ready drops for the NSETS cycles of a flush; s1 requests then come back nacked.
module dcache_s2_pipe #(
   parameter int NWAYS  = 4,
   parameter int TAG_W  = 20,
   parameter int IDX_W  = 6,
   parameter int NBYP   = 3,
   parameter int DATA_W = 64,
   parameter int ROW_W  = 128
) (
   input logic           clk,
   input logic           reset,
   dcache_s2_pipe_if.slave bus
);
   localparam int PADDR_W = TAG_W + IDX_W + 6;
   localparam int NSETS   = 1 << IDX_W;
   localparam int LOGW    = $clog2(NWAYS);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   // Tree nodes are heap-numbered from 1; node n's children are 2n and 2n+1, a bit of 1 steers right.
   function automatic logic [LOGW-1:0] plru_leaf(input logic [NWAYS-2:0] t);
      logic [2*NWAYS-1:0] nodes;
      logic [LOGW:0]      n;
      nodes = '0;
      nodes[NWAYS-1:1] = t;
      n = {{LOGW{1'b0}}, 1'b1};
      for (int l = 0; l < LOGW; l++) n = {n[LOGW-1:0], nodes[n]};
      return n[LOGW-1:0];
   endfunction

   function automatic logic [NWAYS-2:0] plru_touch(input logic [NWAYS-2:0] t, input logic [LOGW-1:0] way);
      logic [2*NWAYS-1:0] nodes;
      logic [LOGW:0]      n;
      nodes = '0;
      nodes[NWAYS-1:1] = t;
      n = {{LOGW{1'b0}}, 1'b1};
      for (int l = LOGW-1; l >= 0; l--) begin
         nodes[n] = ~way[l];
         n = {n[LOGW-1:0], way[l]};
      end
      return nodes[NWAYS-1:1];
   endfunction

   logic [0:0]        state;
   logic [IDX_W-1:0]  flush_idx;
   logic [NWAYS-2:0]  plru [NSETS];

   logic              s1_write;
   logic [IDX_W-1:0]  s1_set;
   logic [IDX_W-1:0]  s2_set;
   logic              plru_upd;
   logic [NWAYS-2:0]  plru_s2_next;
   logic [NWAYS-2:0]  plru_s1;
   logic [NWAYS-1:0]  hit_way;
   logic [LOGW-1:0]   victim_idx;
   logic [LOGW-1:0]   s2_hit_idx;
   logic              byp_hit;
   logic [DATA_W-1:0] byp_sel;
   logic              unused_bits;

   assign bus.s1_ready = (state == IDLE);
   assign s1_write     = (bus.s1_cmd == 5'd1) || (bus.s1_cmd == 5'd4) || (bus.s1_cmd == 5'd7) || bus.s1_cmd[3];
   assign s1_set       = bus.s1_paddr[IDX_W+5:6];
   assign s2_set       = bus.s2_addr[IDX_W+5:6];
   assign plru_upd     = bus.s2_valid & bus.s2_hit & ~bus.s2_nack & (state == IDLE);
   assign plru_s2_next = plru_touch(plru[s2_set], s2_hit_idx);
   // A same-set hit retiring in s2 must be visible to this cycle's victim choice.
   assign plru_s1      = (plru_upd && (s1_set == s2_set)) ? plru_s2_next : plru[s1_set];
   assign unused_bits  = ^{bus.s1_paddr[2:0], bus.byp_addr};

   always_comb begin
      hit_way    = '0;
      s2_hit_idx = '0;
      victim_idx = plru_leaf(plru_s1);
      byp_hit    = 1'b0;
      byp_sel    = bus.s2_bypass_data;
      for (int w = 0; w < NWAYS; w++)
         hit_way[w] = (bus.meta_tag_in[w*TAG_W +: TAG_W] == bus.s1_paddr[PADDR_W-1 -: TAG_W]) &&
                      (bus.meta_state_in[w*2 +: 2] != 2'b00);
      // Descending scans so the lowest index wins.
      for (int w = NWAYS-1; w >= 0; w--) begin
         if (bus.meta_state_in[w*2 +: 2] == 2'b00) victim_idx = LOGW'(w);
         if (bus.s2_hit_way[w]) s2_hit_idx = LOGW'(w);
      end
      for (int i = NBYP-1; i >= 0; i--) begin
         if (bus.byp_valid[i] && bus.byp_write[i] &&
             (bus.byp_addr[i*PADDR_W+3 +: PADDR_W-3] == bus.s1_paddr[PADDR_W-1:3])) begin
            byp_hit = 1'b1;
            byp_sel = bus.byp_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         flush_idx <= '0;
         for (int s = 0; s < NSETS; s++) plru[s] <= '0;
         bus.s2_valid        <= 1'b0;
         bus.s2_killed       <= 1'b0;
         bus.s2_replay       <= 1'b0;
         bus.s2_nack         <= 1'b0;
         bus.s2_hit          <= 1'b0;
         bus.s2_addr         <= '0;
         bus.s2_cmd          <= '0;
         bus.s2_wdata        <= '0;
         bus.s2_hit_way      <= '0;
         bus.s2_victim_way   <= '0;
         bus.s2_meta_tag     <= '0;
         bus.s2_meta_state   <= '0;
         bus.s2_rows         <= '0;
         bus.s2_store_bypass <= 1'b0;
         bus.s2_bypass_data  <= '0;
      end else begin
         if (state == FLUSH) begin
            plru[flush_idx] <= '0;
            flush_idx       <= flush_idx + 1'b1;
            if (flush_idx == IDX_W'(NSETS-1)) state <= IDLE;
         end else begin
            if (plru_upd) plru[s2_set] <= plru_s2_next;
            if (bus.flush) state <= FLUSH;
         end

         bus.s2_valid  <= bus.s1_valid & ~bus.s1_kill & bus.s1_ready;
         bus.s2_killed <= bus.s1_valid & bus.s1_kill;
         bus.s2_replay <= bus.s1_replay & (bus.s1_cmd != 5'd5);
         if (bus.s1_valid | bus.s1_replay) bus.s2_nack <= bus.s1_nack | ~bus.s1_ready;

         bus.s2_hit_way    <= hit_way;
         bus.s2_hit        <= |hit_way;
         bus.s2_victim_way <= {{(NWAYS-1){1'b0}}, 1'b1} << victim_idx;
         bus.s2_meta_tag   <= bus.meta_tag_in;
         bus.s2_meta_state <= bus.meta_state_in;
         bus.s2_rows       <= bus.data_in;

         if (bus.s1_clk_en) begin
            bus.s2_addr         <= bus.s1_paddr;
            bus.s2_cmd          <= bus.s1_cmd;
            if (s1_write) bus.s2_wdata <= bus.s1_wdata;
            bus.s2_store_bypass <= byp_hit;
            bus.s2_bypass_data  <= byp_sel;
         end
      end
   end
endmodule

// File: tb/tb_dcache_s2_pipe.sv
// Randomised and directed bench for dcache_s2_pipe against a cycle-level reference model.
module tb_dcache_s2_pipe;
   localparam int NWAYS   = 4;
   localparam int TAG_W   = 20;
   localparam int IDX_W   = 6;
   localparam int NBYP    = 3;
   localparam int DATA_W  = 64;
   localparam int ROW_W   = 128;
   localparam int PADDR_W = TAG_W + IDX_W + 6;
   localparam int NSETS   = 1 << IDX_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dcache_s2_pipe_if #(.NWAYS(NWAYS), .TAG_W(TAG_W), .IDX_W(IDX_W), .NBYP(NBYP),
                       .DATA_W(DATA_W), .ROW_W(ROW_W)) bus ();

   dcache_s2_pipe #(.NWAYS(NWAYS), .TAG_W(TAG_W), .IDX_W(IDX_W), .NBYP(NBYP),
                    .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors     = 0;
   int miscompares = 0;
   logic [TAG_W-1:0] tag_pool [4] = '{20'hABCDE, 20'h00001, 20'h12345, 20'hFFFFF};

   // Reference PLRU per set: which half is next to evict, and which way within each half.
   bit m_right_half [NSETS];
   bit m_pick1      [NSETS];
   bit m_pick3      [NSETS];
   bit m_flushing;
   int m_fidx;

   logic                   e_valid, e_killed, e_replay, e_nack, e_hit, e_byp;
   logic [PADDR_W-1:0]     e_addr;
   logic [4:0]             e_cmd;
   logic [DATA_W-1:0]      e_wdata, e_bdata;
   logic [NWAYS-1:0]       e_hway, e_vway;
   logic [NWAYS*TAG_W-1:0] e_tag;
   logic [NWAYS*2-1:0]     e_state;
   logic [NWAYS*ROW_W-1:0] e_rows;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PADDR_W-1:0] addr_of(input logic [TAG_W-1:0] tag, input int set);
      return {tag, IDX_W'(set), 6'b0};
   endfunction

   task automatic model_edge();
      int  set1, set2, hw, vic;
      bit  ready, matched;
      if (reset) begin
         for (int s = 0; s < NSETS; s++) begin
            m_right_half[s] = 0; m_pick1[s] = 0; m_pick3[s] = 0;
         end
         m_flushing = 0; m_fidx = 0;
         {e_valid, e_killed, e_replay, e_nack, e_hit, e_byp} = '0;
         e_addr = '0; e_cmd = '0; e_wdata = '0; e_bdata = '0; e_hway = '0; e_vway = '0;
         e_tag = '0; e_state = '0; e_rows = '0;
         return;
      end
      ready = !m_flushing;
      if (e_valid && e_hit && !e_nack && ready) begin
         set2 = int'(e_addr[IDX_W+5:6]);
         hw = 0;
         for (int w = NWAYS-1; w >= 0; w--) if (e_hway[w]) hw = w;
         m_right_half[set2] = (hw < 2);
         if (hw == 0) m_pick1[set2] = 1;
         else if (hw == 1) m_pick1[set2] = 0;
         else if (hw == 2) m_pick3[set2] = 1;
         else m_pick3[set2] = 0;
      end
      set1 = int'(bus.s1_paddr[IDX_W+5:6]);
      vic = -1;
      for (int w = 0; w < NWAYS; w++) if (vic < 0 && bus.meta_state_in[2*w +: 2] == 2'b00) vic = w;
      if (vic < 0) vic = m_right_half[set1] ? (m_pick3[set1] ? 3 : 2) : (m_pick1[set1] ? 1 : 0);
      if (m_flushing) begin
         m_right_half[m_fidx] = 0; m_pick1[m_fidx] = 0; m_pick3[m_fidx] = 0;
         if (m_fidx == NSETS-1) begin m_flushing = 0; m_fidx = 0; end
         else m_fidx++;
      end else if (bus.flush) m_flushing = 1;

      if (bus.s1_valid || bus.s1_replay) e_nack = bus.s1_nack || !ready;
      e_valid  = bus.s1_valid && !bus.s1_kill && ready;
      e_killed = bus.s1_valid && bus.s1_kill;
      e_replay = bus.s1_replay && (bus.s1_cmd != 5'd5);
      e_hway = '0;
      for (int w = 0; w < NWAYS; w++)
         if (bus.meta_tag_in[w*TAG_W +: TAG_W] == bus.s1_paddr[PADDR_W-1 -: TAG_W] &&
             bus.meta_state_in[2*w +: 2] != 2'b00) e_hway[w] = 1'b1;
      e_hit  = |e_hway;
      e_vway = '0;
      e_vway[vic] = 1'b1;
      e_tag = bus.meta_tag_in; e_state = bus.meta_state_in; e_rows = bus.data_in;
      if (bus.s1_clk_en) begin
         e_addr = bus.s1_paddr;
         e_cmd  = bus.s1_cmd;
         if (bus.s1_cmd == 5'd1 || bus.s1_cmd == 5'd4 || bus.s1_cmd == 5'd7 || bus.s1_cmd[3])
            e_wdata = bus.s1_wdata;
         matched = 0;
         for (int i = 0; i < NBYP; i++)
            if (!matched && bus.byp_valid[i] && bus.byp_write[i] &&
                (bus.byp_addr[i*PADDR_W +: PADDR_W] >> 3) == (bus.s1_paddr >> 3)) begin
               matched = 1;
               e_bdata = bus.byp_data[i*DATA_W +: DATA_W];
            end
         e_byp = matched;
      end
   endtask

   task automatic compare_all();
      chk("s1_ready", bus.s1_ready, !m_flushing);
      chk("s2_valid", bus.s2_valid, e_valid);
      chk("s2_killed", bus.s2_killed, e_killed);
      chk("s2_replay", bus.s2_replay, e_replay);
      chk("s2_nack", bus.s2_nack, e_nack);
      chk("s2_hit", bus.s2_hit, e_hit);
      chk("s2_addr", bus.s2_addr, e_addr);
      chk("s2_cmd", bus.s2_cmd, e_cmd);
      chk("s2_wdata", bus.s2_wdata, e_wdata);
      chk("s2_hit_way", bus.s2_hit_way, e_hway);
      chk("s2_victim_way", bus.s2_victim_way, e_vway);
      chk("s2_meta_tag", bus.s2_meta_tag, e_tag);
      chk("s2_meta_state", bus.s2_meta_state, e_state);
      chk("s2_rows", bus.s2_rows, e_rows);
      chk("s2_store_bypass", bus.s2_store_bypass, e_byp);
      chk("s2_bypass_data", bus.s2_bypass_data, e_bdata);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      bus.s1_valid = 0; bus.s1_kill = 0; bus.s1_replay = 0; bus.s1_clk_en = 1;
      bus.s1_paddr = '0; bus.s1_cmd = '0; bus.s1_wdata = '0; bus.s1_nack = 0;
      for (int w = 0; w < NWAYS; w++) begin
         bus.meta_tag_in[w*TAG_W +: TAG_W] = tag_pool[w];
         bus.meta_state_in[2*w +: 2] = 2'd1;
      end
      bus.data_in = '0;
      bus.byp_valid = '0; bus.byp_write = '0; bus.byp_addr = '0; bus.byp_data = '0;
      bus.flush = 0;
   endtask

   task automatic random_inputs();
      int rot;
      logic [TAG_W-1:0] t;
      rot = $urandom_range(0, 3);
      bus.s1_valid  = ($urandom_range(0, 3) != 0);
      bus.s1_kill   = ($urandom_range(0, 9) == 0);
      bus.s1_replay = ($urandom_range(0, 7) == 0);
      bus.s1_clk_en = ($urandom_range(0, 7) != 0);
      bus.s1_nack   = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 4) != 0) ? tag_pool[$urandom_range(0, 3)] : TAG_W'($urandom());
      bus.s1_paddr  = addr_of(t, $urandom_range(0, 3)) | PADDR_W'($urandom_range(0, 63));
      bus.s1_cmd    = 5'($urandom_range(0, 31));
      bus.s1_wdata  = {$urandom(), $urandom()};
      for (int w = 0; w < NWAYS; w++) begin
         bus.meta_tag_in[w*TAG_W +: TAG_W] = tag_pool[(w + rot) % 4];
         bus.meta_state_in[2*w +: 2] = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      end
      for (int k = 0; k < NWAYS*ROW_W/32; k++) bus.data_in[k*32 +: 32] = $urandom();
      for (int i = 0; i < NBYP; i++) begin
         bus.byp_valid[i] = ($urandom_range(0, 1) != 0);
         bus.byp_write[i] = ($urandom_range(0, 2) != 0);
         bus.byp_addr[i*PADDR_W +: PADDR_W] = ($urandom_range(0, 2) != 0) ?
            (bus.s1_paddr ^ PADDR_W'($urandom_range(0, 7))) : PADDR_W'({$urandom(), $urandom()});
         bus.byp_data[i*DATA_W +: DATA_W] = {$urandom(), $urandom()};
      end
      bus.flush = ($urandom_range(0, 249) == 0);
      reset     = ($urandom_range(0, 599) == 0);
   endtask

   initial begin
      logic [PADDR_W-1:0] a;
      int n;
      idle_inputs();
      reset = 1;
      step(); step();
      chk("rst_ready", bus.s1_ready, 1'b1);
      chk("rst_victim", bus.s2_victim_way, 4'b0000);
      reset = 0;

      bus.s1_valid = 1; bus.s1_paddr = addr_of(20'h12345, 5); step();
      chk("hit", bus.s2_hit, 1'b1);
      chk("hit_way", bus.s2_hit_way, 4'b0100);

      bus.meta_state_in[2 +: 2] = 2'd0; bus.s1_paddr = addr_of(20'h55555, 5); step();
      chk("invalid_victim", bus.s2_victim_way, 4'b0010);
      bus.meta_state_in[2 +: 2] = 2'd1;

      for (int w = 0; w < NWAYS; w++) begin bus.s1_paddr = addr_of(tag_pool[w], 5); step(); end
      bus.s1_paddr = addr_of(20'h55555, 5); step();
      chk("plru_victim", bus.s2_victim_way, 4'b0001);
      bus.s1_paddr = addr_of(tag_pool[0], 5); step();
      bus.s1_paddr = addr_of(20'h55555, 5); step();
      chk("fwd_victim", bus.s2_victim_way, 4'b0100);

      a = addr_of(20'h0F0F0, 9) | PADDR_W'(8'h28);
      bus.s1_paddr = a; bus.s1_cmd = 5'd1; bus.s1_wdata = 64'h0123_4567_89AB_CDEF;
      bus.byp_valid = 3'b111; bus.byp_write = 3'b101;
      bus.byp_addr = {a, a, a ^ PADDR_W'(5)};
      bus.byp_data = {64'hCC, 64'hBB, 64'hAA};
      step();
      chk("byp_hit", bus.s2_store_bypass, 1'b1);
      chk("byp_data", bus.s2_bypass_data, 64'hAA);
      chk("store_wdata", bus.s2_wdata, 64'h0123_4567_89AB_CDEF);
      bus.byp_valid = 3'b100; step();
      chk("byp_data_stage2", bus.s2_bypass_data, 64'hCC);
      bus.s1_kill = 1; step();
      chk("kill_valid", bus.s2_valid, 1'b0);
      chk("kill_killed", bus.s2_killed, 1'b1);
      bus.s1_kill = 0; bus.byp_valid = '0; bus.s1_cmd = 5'd0;

      bus.s1_paddr = addr_of(tag_pool[0], 5); bus.flush = 1; step();
      bus.flush = 0;
      n = 0;
      while (!bus.s1_ready && n < 200) begin
         n++;
         if (n == 5) chk("flush_nack", bus.s2_nack, 1'b1);
         step();
      end
      chk("flush_len", n, 64);
      bus.s1_paddr = addr_of(20'h55555, 5); step();
      chk("post_flush_victim", bus.s2_victim_way, 4'b0001);

      bus.s1_valid = 0; bus.flush = 1; step();
      bus.flush = 0;
      for (int k = 0; k < 9; k++) step();
      reset = 1; step();
      chk("rst_mid_flush", bus.s1_ready, 1'b1);
      reset = 0;

      for (int k = 0; k < 3000; k++) begin random_inputs(); step(); end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
